cmd_token_encoder: RTL

CMD_TOKEN_ENCODER -- requirements
Module: cmd_token_encoder

---
 rtl/cmd_token_encoder_pkg.sv | 51 +++++
 rtl/token_down_counter.sv | 36 +++
 rtl/cmd_token_encoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cmd_token_encoder_pkg.sv
// Shared definitions for cmd_token_encoder: opcodes, command token field layout,
// data-count width and FSM state encoding.
package cmd_token_encoder_pkg;

   localparam logic [1:0] OpStp = 2'd0;
   localparam logic [1:0] OpEvp = 2'd1;
   localparam logic [1:0] OpEvb = 2'd2;
   localparam logic [1:0] OpRst = 2'd3;

   localparam int unsigned CmdW      = 16;
   localparam int unsigned OpcodeLsb = 0;
   localparam int unsigned OpcodeW   = 8;
   localparam int unsigned Arg1Lsb   = 8;
   localparam int unsigned Arg1W     = 3;
   localparam int unsigned Arg2Lsb   = 11;
   localparam int unsigned Arg2W     = 5;

   // Wide enough for STP's arg2+1 with the largest 5-bit arg2.
   localparam int unsigned CntW = 6;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCmd  = 2'd1,
      StData = 2'd2,
      StFin  = 2'd3
   } state_e;

   function automatic logic [CmdW-1:0] pack_cmd(input logic [1:0]       op,
                                                 input logic [Arg1W-1:0] a1,
                                                 input logic [Arg2W-1:0] a2);
      logic [CmdW-1:0] tok;
      tok = '0;
      tok[OpcodeLsb +: 2]     = op;
      tok[Arg1Lsb +: Arg1W]   = a1;
      tok[Arg2Lsb +: Arg2W]   = a2;
      return tok;
   endfunction

   function automatic logic [CntW-1:0] data_count(input logic [1:0]       op,
                                                   input logic [Arg2W-1:0] a2);
      logic [CntW-1:0] cnt;
      unique case (op)
         OpStp:   cnt = {1'b0, a2} + CntW'(1);
         OpEvp:   cnt = CntW'(1);
         OpEvb:   cnt = {1'b0, a2};
         default: cnt = '0;
      endcase
      return cnt;
   endfunction

endpackage

// File: rtl/token_down_counter.sv
// Loadable down-counter holding the number of data tokens still owed for a packet.
module token_down_counter #(
   parameter int unsigned Width = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic [Width-1:0] count_o,
   output logic             zero_o
);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/cmd_token_encoder.sv
// Turns host instructions plus data tokens into command/data FIFO writes.
// Define CMD_TOKEN_ATOMIC_EN to hold the command until the whole packet fits in the data FIFO.
module cmd_token_encoder
   import cmd_token_encoder_pkg::*;
#(
   parameter int unsigned word_size = 16,
   parameter int unsigned n_max     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic [1:0]           req_instr,
   input  logic [2:0]           req_arg1,
   input  logic [4:0]           req_arg2,
   output logic                 req_ready,
   input  logic                 dat_valid,
   input  logic [word_size-1:0] dat_in,
   output logic                 dat_ready,
   input  logic [word_size-1:0] free_fifo_command,
   input  logic [word_size-1:0] free_fifo_data,
   output logic                 wr_fifo_command,
   output logic [word_size-1:0] command_out,
   output logic                 wr_fifo_data,
   output logic [word_size-1:0] data_out,
   output logic                 done_tx,
   output logic                 err_tx
);

   state_e state_d, state_q;
   logic [1:0]           op_d, op_q;
   logic [2:0]           arg1_d, arg1_q;
   logic [4:0]           arg2_d, arg2_q;
   logic                 wr_cmd_d, wr_cmd_q;
   logic [word_size-1:0] cmd_d, cmd_q;
   logic                 wr_dat_d, wr_dat_q;
   logic [word_size-1:0] dat_d, dat_q;
   logic                 done_d, done_q;
   logic                 err_d, err_q;

   logic            cnt_load, cnt_dec, cnt_zero;
   logic [CntW-1:0] cnt, cnt_load_val;
   logic            req_bad, cmd_issue, dat_room, dat_fire;

   token_down_counter #(
      .Width (CntW)
   ) u_cnt (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .count_o    (cnt),
      .zero_o     (cnt_zero)
   );

   assign cnt_load_val = data_count(req_instr, req_arg2);
   assign req_bad      = ((req_instr == OpStp) && (32'(req_arg2) > n_max)) ||
                         ((req_instr == OpEvb) && (req_arg2 == '0));

   // A registered write still in flight has not yet reduced free_fifo_data.
   assign dat_room  = free_fifo_data > word_size'(wr_dat_q);
   assign dat_ready = (state_q == StData) && dat_room;
   assign dat_fire  = dat_valid && dat_ready;

   // Gating with rst keeps req_ready low while reset is held even though state is IDLE.
   assign req_ready = (state_q == StIdle) && rst;

`ifdef CMD_TOKEN_ATOMIC_EN
   assign cmd_issue = (free_fifo_command != '0) && (free_fifo_data >= word_size'(cnt));
`else
   assign cmd_issue = (free_fifo_command != '0);
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      arg1_d   = arg1_q;
      arg2_d   = arg2_q;
      wr_cmd_d = 1'b0;
      cmd_d    = cmd_q;
      wr_dat_d = 1'b0;
      dat_d    = dat_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else begin
                  op_d     = req_instr;
                  arg1_d   = req_arg1;
                  arg2_d   = req_arg2;
                  cnt_load = 1'b1;
                  state_d  = StCmd;
               end
            end
         end
         StCmd: begin
            if (cmd_issue) begin
               wr_cmd_d = 1'b1;
               cmd_d    = word_size'(pack_cmd(op_q, arg1_q, arg2_q));
               state_d  = cnt_zero ? StFin : StData;
            end
         end
         StData: begin
            if (dat_fire) begin
               wr_dat_d = 1'b1;
               dat_d    = dat_in;
               cnt_dec  = 1'b1;
               if (cnt == CntW'(1)) begin
                  state_d = StFin;
               end
            end
         end
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         arg1_q   <= '0;
         arg2_q   <= '0;
         wr_cmd_q <= 1'b0;
         cmd_q    <= '0;
         wr_dat_q <= 1'b0;
         dat_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         arg1_q   <= arg1_d;
         arg2_q   <= arg2_d;
         wr_cmd_q <= wr_cmd_d;
         cmd_q    <= cmd_d;
         wr_dat_q <= wr_dat_d;
         dat_q    <= dat_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign wr_fifo_command = wr_cmd_q;
   assign command_out     = cmd_q;
   assign wr_fifo_data    = wr_dat_q;
   assign data_out        = dat_q;
   assign done_tx         = done_q;
   assign err_tx          = err_q;

endmodule
